// File: rtl/ahb_resp_mux_if.sv
// AHB-Lite response mux bus bundle: decoder/slave inputs and muxed master outputs.
// The slave modport is the mux itself; the master modport drives it.
interface ahb_resp_mux_if #(
    parameter int NS = 5,
    parameter int DW = 32
);
    logic [NS-1:0]    hsel_in;
    logic [1:0]       htrans;
    logic [NS*DW-1:0] hrdata_s;
    logic [NS-1:0]    hreadyout_s;
    logic [NS-1:0]    hresp_s;
    logic [DW-1:0]    hrdata;
    logic             hready;
    logic             hresp;
    logic             sel_err;

    modport slave (
        input  hsel_in, htrans, hrdata_s, hreadyout_s, hresp_s,
        output hrdata, hready, hresp, sel_err
    );

    modport master (
        output hsel_in, htrans, hrdata_s, hreadyout_s, hresp_s,
        input  hrdata, hready, hresp, sel_err
    );
endinterface

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response mux with data-phase select
// tracking and a built-in two-cycle ERROR default slave.
module ahb_resp_mux #(
    parameter int NS = 5,
    parameter int DW = 32
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_resp_mux_if.slave  bus
);
    typedef enum logic [1:0] {
        D_IDLE,
        D_ERR1,
        D_ERR2
    } dstate_t;

    dstate_t       st, st_d;
    logic [NS-1:0] dsel, dsel_d;
    logic          err_d, sel_err_q;
    logic          multi, none;
    logic [DW-1:0] rd;
    logic          rdy, rsp;

    always_comb begin
        multi  = |(bus.hsel_in & (bus.hsel_in - NS'(1)));
        none   = ~|bus.hsel_in;
        st_d   = st;
        dsel_d = dsel;
        err_d  = 1'b0;
        // ERR1 stalls the bus, so it is never a capture cycle
        if (st == D_ERR1) begin
            st_d = D_ERR2;
        end else if (bus.hready) begin
            st_d   = D_IDLE;
            dsel_d = '0;
            unique case (1'b1)
                multi: begin
                    err_d = 1'b1;
                    if (bus.htrans[1]) st_d = D_ERR1;
                end
                none: begin
                    if (bus.htrans[1]) st_d = D_ERR1;
                end
                default: dsel_d = bus.hsel_in;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            st        <= D_IDLE;
            dsel      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            st        <= st_d;
            dsel      <= dsel_d;
            sel_err_q <= err_d;
        end
    end

    always_comb begin
        rd  = '0;
        rdy = 1'b0;
        rsp = 1'b0;
        for (int i = 0; i < NS; i++) begin
            rd  = rd | ({DW{dsel[i]}} & bus.hrdata_s[i*DW +: DW]);
            rdy = rdy | (dsel[i] & bus.hreadyout_s[i]);
            rsp = rsp | (dsel[i] & bus.hresp_s[i]);
        end
        if (dsel == '0) begin
            unique case (st)
                D_ERR1:  begin rdy = 1'b0; rsp = 1'b1; end
                D_ERR2:  begin rdy = 1'b1; rsp = 1'b1; end
                default: begin rdy = 1'b1; rsp = 1'b0; end
            endcase
        end
    end

    assign bus.hrdata  = rd;
    assign bus.hready  = rdy;
    assign bus.hresp   = rsp;
    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux (NS=5, DW=32).
// Each observation packs {sel_err, hready, hresp, hrdata}.
module tb_ahb_resp_mux;
    localparam int NS = 5;
    localparam int DW = 32;
    localparam logic [34:0] OK  = {3'b010, 32'h0};
    localparam logic [34:0] E1  = {3'b001, 32'h0};
    localparam logic [34:0] E2  = {3'b011, 32'h0};
    localparam logic [34:0] SE1 = {3'b101, 32'h0};
    localparam logic [34:0] SOK = {3'b110, 32'h0};

    logic hclk, hreset, clk_en;
    logic [DW-1:0] sd [NS];
    logic [34:0] got;
    int vec, bad;

    ahb_resp_mux_if #(.NS(NS), .DW(DW)) bus ();

    ahb_resp_mux #(.NS(NS), .DW(DW)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always begin
        #5;
        if (clk_en) hclk = ~hclk;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) bus.hrdata_s[i*DW +: DW] = sd[i];
    end

    assign got = {bus.sel_err, bus.hready, bus.hresp, bus.hrdata};

    task automatic test_reset();
        clk_en = 1'b0;
        hreset = 1'b0;
        #3 hreset = 1'b1;
        #1;
        vec++;
        if (got !== OK) begin
            bad++;
            $display("FAIL reset_async: got %h exp %h", got, OK);
        end
        clk_en = 1'b1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            vec++;
            if (got !== OK) begin
                bad++;
                $display("FAIL reset_idle c%0d: got %h exp %h", i, got, OK);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_wait();
        logic [NS-1:0] sel [5];
        logic [1:0]    tr  [5];
        logic [NS-1:0] ro  [5];
        logic [34:0]   ex  [5];
        sel = '{5'b00100, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
        tr  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        ro  = '{5'b11111, 5'b11011, 5'b11011, 5'b11111, 5'b11111};
        ex  = '{OK, {3'b000, 32'hCAFE_0002}, {3'b000, 32'hCAFE_0002},
                {3'b010, 32'hCAFE_0002}, OK};
        sd[2] = 32'hCAFE_0002;
        for (int i = 0; i < 5; i++) begin
            bus.hsel_in     = sel[i];
            bus.htrans      = tr[i];
            bus.hreadyout_s = ro[i];
            @(negedge hclk);
            vec++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL wait c%0d: got %h exp %h", i, got, ex[i]);
            end
            @(posedge hclk);
            #1;
        end
        sd[2] = 32'hD00D_0002;
    endtask

    task automatic test_back_to_back();
        logic [NS-1:0] sel [5];
        logic [1:0]    tr  [5];
        logic [34:0]   ex  [5];
        sel = '{5'b00001, 5'b01000, 5'b10000, 5'b00000, 5'b00000};
        tr  = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        ex  = '{OK, {3'b010, 32'hD00D_0000}, {3'b010, 32'hD00D_0003},
                {3'b010, 32'hD00D_0004}, OK};
        bus.hreadyout_s = 5'b11101;
        bus.hresp_s     = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            bus.hsel_in = sel[i];
            bus.htrans  = tr[i];
            @(negedge hclk);
            vec++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL b2b c%0d: got %h exp %h", i, got, ex[i]);
            end
            @(posedge hclk);
            #1;
        end
        bus.hreadyout_s = '1;
        bus.hresp_s     = '0;
    endtask

    task automatic test_unmapped();
        logic [NS-1:0] sel [5];
        logic [1:0]    tr  [5];
        logic [34:0]   ex  [5];
        sel = '{5'b00000, 5'b00001, 5'b00010, 5'b00000, 5'b00000};
        tr  = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        ex  = '{OK, E1, E2, {3'b010, 32'hD00D_0001}, OK};
        for (int i = 0; i < 5; i++) begin
            bus.hsel_in = sel[i];
            bus.htrans  = tr[i];
            @(negedge hclk);
            vec++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL unmapped c%0d: got %h exp %h", i, got, ex[i]);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_idle_multi();
        logic [NS-1:0] sel [6];
        logic [1:0]    tr  [6];
        logic [34:0]   ex  [6];
        sel = '{5'b00000, 5'b10010, 5'b00100, 5'b10010, 5'b00000, 5'b00000};
        tr  = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
        ex  = '{OK, OK, SE1, E2, SOK, OK};
        for (int i = 0; i < 6; i++) begin
            bus.hsel_in = sel[i];
            bus.htrans  = tr[i];
            @(negedge hclk);
            vec++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL multi c%0d: got %h exp %h", i, got, ex[i]);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_reset_mid_error();
        logic [34:0] ex [3];
        ex = '{OK, {3'b010, 32'hD00D_0000}, OK};
        bus.hsel_in = '0;
        bus.htrans  = 2'd2;
        @(negedge hclk);
        vec++;
        if (got !== OK) begin
            bad++;
            $display("FAIL rsterr_pre: got %h exp %h", got, OK);
        end
        @(posedge hclk);
        #1;
        bus.htrans = 2'd0;
        vec++;
        if (got !== E1) begin
            bad++;
            $display("FAIL rsterr_err1: got %h exp %h", got, E1);
        end
        hreset = 1'b1;
        #1;
        vec++;
        if (got !== OK) begin
            bad++;
            $display("FAIL rsterr_async: got %h exp %h", got, OK);
        end
        @(posedge hclk);
        #1 hreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.hsel_in = (i == 0) ? 5'b00001 : 5'b00000;
            bus.htrans  = (i == 0) ? 2'd2 : 2'd0;
            @(negedge hclk);
            vec++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL rsterr_post c%0d: got %h exp %h", i, got, ex[i]);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        vec = 0;
        bad = 0;
        clk_en = 1'b0;
        hreset = 1'b0;
        bus.hsel_in     = '0;
        bus.htrans      = 2'd0;
        bus.hreadyout_s = '1;
        bus.hresp_s     = '0;
        for (int i = 0; i < NS; i++) sd[i] = 32'hD00D_0000 | i;
        test_reset();
        test_wait();
        test_back_to_back();
        test_unmapped();
        test_idle_multi();
        test_reset_mid_error();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
